// File: rtl/sim_stim_sequencer.sv
// Board-stimulus sequencer: pulses the DUT reset on KEY[0], steps SW through a vector table,
// snapshots the HEX bus at the end of each hold and flags HEX changes. Optional macro: STIM_LOOP_EN.
module sim_stim_sequencer #(
  parameter int SW_WIDTH    = 18,
  parameter int KEY_WIDTH   = 4,
  parameter int HEX_DIGITS  = 8,
  parameter int NUM_VECTORS = 4,
  parameter int RST_CYCLES  = 2,
  parameter int HOLD_CYCLES = 1000,
  localparam int IDX_W      = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_VECTORS*SW_WIDTH-1:0] vec_table,
  input  logic [HEX_DIGITS*7-1:0]         hex_in,
  output logic [KEY_WIDTH-1:0]            KEY,
  output logic [SW_WIDTH-1:0]             SW,
  output logic [IDX_W-1:0]                vec_idx,
  output logic                            sample_stb,
  output logic [HEX_DIGITS*7-1:0]         hex_snapshot,
  output logic                            hex_changed,
  output logic                            done
);

  localparam int CNT_MAX = (RST_CYCLES > HOLD_CYCLES) ? RST_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int HEX_W   = HEX_DIGITS * 7;

  localparam logic [1:0] ST_RST_PULSE = 2'd0;
  localparam logic [1:0] ST_HOLD      = 2'd1;
  localparam logic [1:0] ST_DONE      = 2'd2;

  localparam logic [CNT_W-1:0]     RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]     HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_VECTORS - 1);
  localparam logic [KEY_WIDTH-1:0] KEY_RESET = ~(KEY_WIDTH'(1));

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stb_q, stb_d;
  logic [HEX_W-1:0]     snap_q, snap_d;
  logic                 chg_q, chg_d;
  logic                 done_q, done_d;
  logic [HEX_W-1:0]     hex_prev_q, hex_prev_d;

  logic [SW_WIDTH-1:0]  vec_arr [NUM_VECTORS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_VECTORS; i++) begin
      vec_arr[i] = vec_table[i*SW_WIDTH +: SW_WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_d      = key_q;
    idx_d      = idx_q;
    stb_d      = 1'b0;
    snap_d     = snap_q;
`ifdef STIM_LOOP_EN
    done_d     = 1'b0;
`else
    done_d     = done_q;
`endif
    hex_prev_d = hex_in;
    // DUT outputs are meaningless while it is held in reset, so no change flag then
    chg_d      = (state_q != ST_RST_PULSE) && (hex_in != hex_prev_q);

    case (state_q)
      ST_RST_PULSE: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_HOLD;
          key_d   = '1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          snap_d = hex_in;
          stb_d  = 1'b1;
          cnt_d  = '0;
          if (idx_q == IDX_LAST) begin
`ifdef STIM_LOOP_EN
            idx_d   = '0;
            state_d = ST_RST_PULSE;
            key_d   = KEY_RESET;
            done_d  = 1'b1;
`else
            state_d = ST_DONE;
            done_d  = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: ;
      default: state_d = ST_RST_PULSE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RST_PULSE;
      cnt_q      <= '0;
      key_q      <= KEY_RESET;
      idx_q      <= '0;
      stb_q      <= 1'b0;
      snap_q     <= '0;
      chg_q      <= 1'b0;
      done_q     <= 1'b0;
      hex_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      idx_q      <= idx_d;
      stb_q      <= stb_d;
      snap_q     <= snap_d;
      chg_q      <= chg_d;
      done_q     <= done_d;
      hex_prev_q <= hex_prev_d;
    end
  end

  // The table is static, so SW is a lookup by the registered index and changes only on clk/rst
  assign SW           = vec_arr[idx_q];
  assign KEY          = key_q;
  assign vec_idx      = idx_q;
  assign sample_stb   = stb_q;
  assign hex_snapshot = snap_q;
  assign hex_changed  = chg_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sim_stim_sequencer.sv
// Self-checking bench for sim_stim_sequencer: directed vector table, hand-written corner
// sequences and randomized runs against a timeline model of the stimulus sequence.
module tb_sim_stim_sequencer;

  localparam int SW_W  = 18;
  localparam int KEY_W = 4;
  localparam int HEX_D = 8;
  localparam int NV    = 3;
  localparam int RC    = 2;
  localparam int HC    = 4;
  localparam int HW    = HEX_D * 7;
  localparam int P     = RC + NV * HC;

  localparam logic [HW-1:0] C0   = 56'h7F7F7F7F7F7F40;
  localparam logic [HW-1:0] C1   = C0 ^ 56'h39;
  localparam logic [HW-1:0] ZERO = '0;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NV*SW_W-1:0]   vec_table;
  logic [HW-1:0]        hex_in;
  logic [KEY_W-1:0]     KEY;
  logic [SW_W-1:0]      SW;
  logic [1:0]           vec_idx;
  logic                 sample_stb;
  logic [HW-1:0]        hex_snapshot;
  logic                 hex_changed;
  logic                 done;

  sim_stim_sequencer #(
    .SW_WIDTH(SW_W), .KEY_WIDTH(KEY_W), .HEX_DIGITS(HEX_D),
    .NUM_VECTORS(NV), .RST_CYCLES(RC), .HOLD_CYCLES(HC)
  ) dut (
    .clk(clk), .rst(rst), .vec_table(vec_table), .hex_in(hex_in),
    .KEY(KEY), .SW(SW), .vec_idx(vec_idx), .sample_stb(sample_stb),
    .hex_snapshot(hex_snapshot), .hex_changed(hex_changed), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  // u = number of clk edges since rst was released; hexh[u] = hex_in seen at edge u
  logic [SW_W-1:0] vt [NV];
  logic [HW-1:0]   hexh [256];
  logic [HW-1:0]   snap_m;
  int              u;

  function automatic int pos_of(input int x);
`ifdef STIM_LOOP_EN
    return x % P;
`else
    return x;
`endif
  endfunction

  function automatic bit in_hold(input int x);
    return pos_of(x) >= RC;
  endfunction

  function automatic int idx_of(input int x);
    int p = pos_of(x);
    int k;
    if (p < RC) return 0;
    k = (p - RC) / HC;
    return (k > NV - 1) ? NV - 1 : k;
  endfunction

  function automatic bit is_sample(input int x);
    int p = pos_of(x);
    if (x == 0) return 1'b0;
`ifdef STIM_LOOP_EN
    if (p == 0) return 1'b1;
    return (p > RC) && ((p - RC) % HC == 0);
`else
    return (p > RC) && ((p - RC) % HC == 0) && ((p - RC) / HC <= NV);
`endif
  endfunction

  function automatic bit is_done(input int x);
`ifdef STIM_LOOP_EN
    return (x > 0) && (x % P == 0);
`else
    return x >= P;
`endif
  endfunction

  task automatic pack_table();
    for (int i = 0; i < NV; i++) vec_table[i*SW_W +: SW_W] = vt[i];
  endtask

  task automatic check_model(input string tag);
    logic [KEY_W-1:0] key_e;
    bit               chg_e;
    key_e = in_hold(u) ? 4'hf : 4'he;
    chg_e = (u > 0) && in_hold(u - 1) && (hexh[u] != hexh[u-1]);
    chk($sformatf("%s.u%0d.key", tag, u),  64'(KEY),          64'(key_e));
    chk($sformatf("%s.u%0d.sw", tag, u),   64'(SW),           64'(vt[idx_of(u)]));
    chk($sformatf("%s.u%0d.idx", tag, u),  64'(vec_idx),      64'(idx_of(u)));
    chk($sformatf("%s.u%0d.stb", tag, u),  64'(sample_stb),   64'(is_sample(u)));
    chk($sformatf("%s.u%0d.snap", tag, u), 64'(hex_snapshot), 64'(snap_m));
    chk($sformatf("%s.u%0d.chg", tag, u),  64'(hex_changed),  64'(chg_e));
    chk($sformatf("%s.u%0d.done", tag, u), 64'(done),         64'(is_done(u)));
  endtask

  // Asserts rst asynchronously (checked before the next edge), then releases it at a negedge
  task automatic start_run(input string tag, input logic [HW-1:0] h);
    rst = 1'b1;
    pack_table();
    hex_in = h;
    #1;
    u = 0;
    snap_m = '0;
    hexh[0] = h;
    check_model(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input string tag, input logic [HW-1:0] h);
    hex_in = h;
    @(posedge clk);
    #1;
    u++;
    hexh[u] = h;
    if (is_sample(u)) snap_m = h;
    check_model(tag);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [HW-1:0]    hex;
    logic [KEY_W-1:0] key;
    logic [SW_W-1:0]  sw;
    int               idx;
    bit               stb;
    bit               dn;
    bit               chg;
    logic [HW-1:0]    snap;
  } row_t;

  row_t tbl [17];

  initial begin
    logic [63:0]     r64;
    logic [HW-1:0]   h;
    int              len;
    logic [SW_W-1:0] v0, v1, v2;

    rst = 1'b1;
    hex_in = '0;
    vec_table = '0;
    v0 = 18'd12345;
    v1 = 18'd7;
    v2 = 18'h3FFFF;

    tbl[0]  = '{C0, 4'he, v0, 0, 0, 0, 0, ZERO};
    tbl[1]  = '{C0, 4'he, v0, 0, 0, 0, 0, ZERO};
    tbl[2]  = '{C0, 4'hf, v0, 0, 0, 0, 0, ZERO};
    tbl[3]  = '{C0, 4'hf, v0, 0, 0, 0, 0, ZERO};
    tbl[4]  = '{C0, 4'hf, v0, 0, 0, 0, 0, ZERO};
    tbl[5]  = '{C0, 4'hf, v0, 0, 0, 0, 0, ZERO};
    tbl[6]  = '{C0, 4'hf, v1, 1, 1, 0, 0, C0};
    tbl[7]  = '{C0, 4'hf, v1, 1, 0, 0, 0, C0};
    tbl[8]  = '{C0, 4'hf, v1, 1, 0, 0, 0, C0};
    tbl[9]  = '{C0, 4'hf, v1, 1, 0, 0, 0, C0};
    tbl[10] = '{C0, 4'hf, v2, 2, 1, 0, 0, C0};
    tbl[11] = '{C0, 4'hf, v2, 2, 0, 0, 0, C0};
    tbl[12] = '{C0, 4'hf, v2, 2, 0, 0, 0, C0};
    tbl[13] = '{C0, 4'hf, v2, 2, 0, 0, 0, C0};
`ifdef STIM_LOOP_EN
    tbl[14] = '{C0, 4'he, v0, 0, 1, 1, 0, C0};
    tbl[15] = '{C0, 4'he, v0, 0, 0, 0, 0, C0};
    tbl[16] = '{C0, 4'hf, v0, 0, 0, 0, 0, C0};
`else
    tbl[14] = '{C0, 4'hf, v2, 2, 1, 1, 0, C0};
    tbl[15] = '{C0, 4'hf, v2, 2, 0, 1, 0, C0};
    tbl[16] = '{C0, 4'hf, v2, 2, 0, 1, 0, C0};
`endif

    vt[0] = v0; vt[1] = v1; vt[2] = v2;
    pack_table();
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      hex_in = tbl[i].hex;
      if (i == 0) begin
        #1;
      end else begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("tbl%0d.key", i),  64'(KEY),          64'(tbl[i].key));
      chk($sformatf("tbl%0d.sw", i),   64'(SW),           64'(tbl[i].sw));
      chk($sformatf("tbl%0d.idx", i),  64'(vec_idx),      64'(tbl[i].idx));
      chk($sformatf("tbl%0d.stb", i),  64'(sample_stb),   64'(tbl[i].stb));
      chk($sformatf("tbl%0d.done", i), 64'(done),         64'(tbl[i].dn));
      chk($sformatf("tbl%0d.chg", i),  64'(hex_changed),  64'(tbl[i].chg));
      chk($sformatf("tbl%0d.snap", i), 64'(hex_snapshot), 64'(tbl[i].snap));
      if (i == 0) begin
        @(negedge clk);
        rst = 1'b0;
      end
    end

    // Change detection: toggle during the reset pulse is ignored, toggle mid-hold pulses once
    start_run("t4", C0);
    step("t4", C1); chk("t4.rst_toggle_a", 64'(hex_changed), 64'd0);
    step("t4", C0); chk("t4.rst_toggle_b", 64'(hex_changed), 64'd0);
    step("t4", C0); chk("t4.steady",       64'(hex_changed), 64'd0);
    step("t4", C1); chk("t4.hold_toggle",  64'(hex_changed), 64'd1);
    step("t4", C1); chk("t4.pulse_end",    64'(hex_changed), 64'd0);

    // Mid-run reset while vector 1 is applied, then a full replay from vector 0
    step("t5", C1); step("t5", C1); step("t5", C1);
    chk("t5.on_vec1", 64'(vec_idx), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5.async_key",  64'(KEY),          64'hE);
    chk("t5.async_sw",   64'(SW),           64'(v0));
    chk("t5.async_idx",  64'(vec_idx),      64'd0);
    chk("t5.async_snap", 64'(hex_snapshot), 64'd0);
    chk("t5.async_stb",  64'(sample_stb),   64'd0);
    chk("t5.async_chg",  64'(hex_changed),  64'd0);
    chk("t5.async_done", 64'(done),         64'd0);
    start_run("t5r", C0);
    for (int i = 0; i < P + 3; i++) step("t5r", (i == 7) ? C1 : C0);

    // Randomized runs: fresh table each time, random HEX activity, random mid-run resets
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NV; i++) vt[i] = SW_W'($urandom);
      r64 = {$urandom(), $urandom()};
      h = r64[HW-1:0];
      start_run("rnd", h);
      len = $urandom_range(5, 3 * P);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          r64 = {$urandom(), $urandom()};
          h = r64[HW-1:0];
        end
        step("rnd", h);
      end
    end

    rst = 1'b1;
    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
